// File: rtl/popcount_arbiter.sv
// Round-robin arbiter sharing one combinational popcount unit between NREQ byte requesters.
// Define POPCOUNT_ARBITER_STATS_EN to add the saturating total_ones accumulator output.
//
// state   | meaning
// IDLE    | waiting for a request; round-robin winner is granted combinationally
// COMPUTE | winner's byte latched in operand register, popcount being registered
// RESPOND | rsp_valid high, rsp_count/rsp_id frozen until rsp_ready

module popcount_arbiter #(
   parameter int NREQ = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [8*NREQ-1:0]       req_data,
   output logic [NREQ-1:0]         req_ready,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [3:0]              rsp_count,
   output logic [$clog2(NREQ)-1:0] rsp_id,
   output logic                    busy
`ifdef POPCOUNT_ARBITER_STATS_EN
   ,
   output logic [15:0]             total_ones
`endif
);

   localparam int ID_W = $clog2(NREQ);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPUTE = 2'd1,
      RESPOND = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [7:0]        operand;
   logic [ID_W-1:0]   id_reg;
   logic [ID_W-1:0]   last_grant;
   logic [ID_W-1:0]   grant_idx;
   logic [ID_W-1:0]   cand;
   logic              grant_found;
   logic              accept;
   logic [3:0]        add_bits_out;
   logic [7:0]        req_bytes [NREQ];

   function automatic logic [3:0] add_bits(input logic [7:0] val);
      logic [3:0] cnt;
      cnt = '0;
      for (int b = 0; b < 8; b++) begin
         cnt = cnt + {3'b000, val[b]};
      end
      return cnt;
   endfunction

   for (genvar i = 0; i < NREQ; i++) begin : g_bytes
      assign req_bytes[i] = req_data[8*i +: 8];
   end

   // Search upward from last_grant+1 with wrap; first valid requester wins.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = last_grant;
      for (int k = 0; k < NREQ; k++) begin
         cand = (cand == ID_W'(NREQ - 1)) ? '0 : cand + ID_W'(1);
         if (!grant_found && req_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   assign accept       = (state == IDLE) && grant_found;
   assign add_bits_out = add_bits(operand);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant_found) state_nxt = COMPUTE;
         COMPUTE: state_nxt = RESPOND;
         RESPOND: if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // req_ready is gated by rst_n so no grant is advertised while held in reset.
   always_comb begin
      req_ready = '0;
      if (accept && rst_n) begin
         req_ready[grant_idx] = 1'b1;
      end
      rsp_valid = (state == RESPOND);
      busy      = (state != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         operand    <= '0;
         id_reg     <= '0;
         last_grant <= ID_W'(NREQ - 1);
         rsp_count  <= '0;
      end else begin
         if (accept) begin
            operand    <= req_bytes[grant_idx];
            id_reg     <= grant_idx;
            last_grant <= grant_idx;
         end
         if (state == COMPUTE) begin
            rsp_count <= add_bits_out;
         end
      end
   end

   assign rsp_id = id_reg;

`ifdef POPCOUNT_ARBITER_STATS_EN
   logic [16:0] ones_sum;

   assign ones_sum = {1'b0, total_ones} + {13'b0, rsp_count};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         total_ones <= '0;
      end else if (rsp_valid && rsp_ready) begin
         total_ones <= ones_sum[16] ? 16'hFFFF : ones_sum[15:0];
      end
   end
`endif

endmodule
